alu_exec_unit: RTL and testbench

//  Parametrised execute stage: decodes ALUOp/funct3/funct7 and computes the RV32I ALU result plus RV M-extension ops.

---
 rtl/alu_exec_unit.sv | 198 +++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// RV32I ALU plus iterative RV M-extension execute stage with valid/ready handshake on both sides.
// Base ops complete in one cycle; mul/div run a bit-serial loop on magnitudes with a final sign fix-up.
module alu_exec_unit #(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic            funct7b5,
  input  logic            funct7b0,
  input  logic            opb5,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);
  localparam int SHW = $clog2(XLEN);
  localparam int CW  = SHW + 1;
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t r_state, w_state_nx;

  logic [2*XLEN-1:0] r_acc, w_acc_nx, w_prod;
  logic [XLEN-1:0]   r_opnd, r_result;
  logic [CW-1:0]     r_cnt;
  logic [2:0]        r_f3;
  logic              r_neg, r_zero, r_illegal;

  logic              w_is_m, w_m_op, w_illegal, w_div_special;
  logic              w_a_sgn, w_b_sgn, w_a_neg, w_b_neg, w_res_neg;
  logic [XLEN-1:0]   w_a_mag, w_b_mag, w_base, w_imm_res;
  logic [XLEN-1:0]   w_hi, w_lo, w_q, w_r, w_fix;
  logic [XLEN:0]     w_sum, w_rs, w_diff;
  logic [SHW-1:0]    w_shamt;
  logic signed [XLEN-1:0] w_sra;

  assign w_is_m    = (alu_op == 2'b10) && opb5 && funct7b0;
  assign w_m_op    = w_is_m && ENABLE_M;
  assign w_illegal = (alu_op == 2'b11) || (w_is_m && !ENABLE_M);
  assign w_shamt   = src_b[SHW-1:0];
  assign w_sra     = $signed(src_a) >>> w_shamt;

  // Operand signedness: mulh/mulhsu/div/rem treat A as signed; mulh/div/rem treat B as signed.
  assign w_a_sgn   = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
  assign w_b_sgn   = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
  assign w_a_neg   = w_a_sgn && src_a[XLEN-1];
  assign w_b_neg   = w_b_sgn && src_b[XLEN-1];
  assign w_a_mag   = w_a_neg ? (~src_a + 1'b1) : src_a;
  assign w_b_mag   = w_b_neg ? (~src_b + 1'b1) : src_b;
  assign w_res_neg = (funct3[2:1] == 2'b11) ? w_a_neg : (w_a_neg ^ w_b_neg);

  assign w_div_special = w_m_op && funct3[2] &&
                         ((src_b == '0) || (!funct3[0] && (src_a == MIN_VAL) && (src_b == '1)));

  always_comb begin
    w_base = '0;
    case (alu_op)
      2'b00: w_base = src_a + src_b;
      2'b01: w_base = src_a - src_b;
      2'b10: begin
        case (funct3)
          3'b000: begin
            if (funct7b5 && opb5) w_base = src_a - src_b;
            else                  w_base = src_a + src_b;
          end
          3'b001: w_base = src_a << w_shamt;
          3'b010: w_base = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
          3'b011: w_base = {{(XLEN-1){1'b0}}, (src_a < src_b)};
          3'b100: w_base = src_a ^ src_b;
          3'b101: begin
            if (funct7b5) w_base = w_sra;
            else          w_base = src_a >> w_shamt;
          end
          3'b110: w_base = src_a | src_b;
          default: w_base = src_a & src_b;
        endcase
      end
      default: w_base = '0;
    endcase
  end

  always_comb begin
    w_imm_res = w_base;
    if (w_illegal) begin
      w_imm_res = '0;
    end else if (w_div_special) begin
      if (src_b == '0) w_imm_res = funct3[1] ? src_a : '1;
      else             w_imm_res = funct3[1] ? '0 : MIN_VAL;
    end
  end

  // Shared accumulator: {partial product, multiplier} for mul, {remainder, dividend/quotient} for div.
  assign w_hi = r_acc[2*XLEN-1:XLEN];
  assign w_lo = r_acc[XLEN-1:0];

  always_comb begin
    w_sum    = {1'b0, w_hi} + (w_lo[0] ? {1'b0, r_opnd} : '0);
    w_rs     = {w_hi, w_lo[XLEN-1]};
    w_diff   = w_rs - {1'b0, r_opnd};
    w_acc_nx = r_acc;
    if (r_f3[2]) begin
      if (!w_diff[XLEN]) w_acc_nx = {w_diff[XLEN-1:0], w_lo[XLEN-2:0], 1'b1};
      else               w_acc_nx = {w_rs[XLEN-1:0], w_lo[XLEN-2:0], 1'b0};
    end else begin
      w_acc_nx = {w_sum, w_lo[XLEN-1:1]};
    end
  end

  always_comb begin
    w_prod = r_neg ? (~w_acc_nx + 1'b1) : w_acc_nx;
    w_q    = r_neg ? (~w_acc_nx[XLEN-1:0] + 1'b1) : w_acc_nx[XLEN-1:0];
    w_r    = r_neg ? (~w_acc_nx[2*XLEN-1:XLEN] + 1'b1) : w_acc_nx[2*XLEN-1:XLEN];
    case (r_f3)
      3'b000:         w_fix = w_prod[XLEN-1:0];
      3'b001, 3'b010,
      3'b011:         w_fix = w_prod[2*XLEN-1:XLEN];
      3'b100, 3'b101: w_fix = w_q;
      default:        w_fix = w_r;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    if (flush) begin
      w_state_nx = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (in_valid) w_state_nx = (w_m_op && !w_div_special) ? BUSY : DONE;
        BUSY:    if (r_cnt == CW'(1)) w_state_nx = DONE;
        DONE:    if (out_ready) w_state_nx = IDLE;
        default: w_state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_opnd    <= '0;
      r_cnt     <= '0;
      r_f3      <= '0;
      r_neg     <= 1'b0;
      r_result  <= '0;
      r_zero    <= 1'b1;
      r_illegal <= 1'b0;
    end else if (flush) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_illegal <= w_illegal;
            r_f3      <= funct3;
            r_neg     <= w_res_neg;
            r_opnd    <= w_b_mag;
            if (w_m_op && !w_div_special) begin
              r_acc <= {{XLEN{1'b0}}, w_a_mag};
              r_cnt <= CW'(XLEN);
            end else begin
              r_result <= w_imm_res;
              r_zero   <= (w_imm_res == '0);
            end
          end
        end
        BUSY: begin
          r_acc <= w_acc_nx;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_result <= w_fix;
            r_zero   <= (w_fix == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign result    = r_result;
  assign zero      = r_zero;
  assign illegal   = r_illegal && out_valid;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: base ops, M-ext ops, divide specials, backpressure, flush, reset.
module tb_alu_exec_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  alu_op = 2'b00;
  logic [2:0]  funct3 = 3'b000;
  logic        funct7b5 = 1'b0;
  logic        funct7b0 = 1'b0;
  logic        opb5 = 1'b0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int pass_cnt = 0;
  int total_cnt = 0;

  alu_exec_unit #(.XLEN(32), .ENABLE_M(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct3(funct3), .funct7b5(funct7b5), .funct7b0(funct7b0), .opb5(opb5),
    .src_a(src_a), .src_b(src_b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [2:0]  f3;
    logic        f7b5;
    logic        f7b0;
    logic        ob5;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t base_vecs [0:13] = '{
    '{2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 32'd5,        32'd7,        32'hFFFF_FFFE, 1},
    '{2'b10, 3'b000, 1'b1, 1'b0, 1'b0, 32'd3,        32'd3,        32'd6,         1},
    '{2'b10, 3'b001, 1'b0, 1'b0, 1'b1, 32'd1,        32'd31,       32'h8000_0000, 1},
    '{2'b10, 3'b001, 1'b0, 1'b0, 1'b1, 32'd1,        32'd33,       32'd2,         1},
    '{2'b10, 3'b010, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1,       32'd1,         1},
    '{2'b10, 3'b011, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1,       32'd0,         1},
    '{2'b10, 3'b010, 1'b0, 1'b0, 1'b1, 32'd1,        32'hFFFF_FFFF, 32'd0,        1},
    '{2'b10, 3'b011, 1'b0, 1'b0, 1'b1, 32'd1,        32'hFFFF_FFFF, 32'd1,        1},
    '{2'b10, 3'b100, 1'b0, 1'b0, 1'b1, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 1},
    '{2'b10, 3'b101, 1'b1, 1'b0, 1'b1, 32'h8000_0000, 32'd4,       32'hF800_0000, 1},
    '{2'b10, 3'b101, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 32'd4,       32'h0800_0000, 1},
    '{2'b10, 3'b110, 1'b0, 1'b0, 1'b1, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 1},
    '{2'b10, 3'b111, 1'b0, 1'b0, 1'b1, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1},
    '{2'b10, 3'b000, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1,       32'd0,         1}
  };

  vec_t m_vecs [0:9] = '{
    '{2'b10, 3'b000, 1'b0, 1'b1, 1'b1, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33},
    '{2'b10, 3'b001, 1'b0, 1'b1, 1'b1, 32'h4000_0000, 32'd4,         32'd1,         33},
    '{2'b10, 3'b010, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 33},
    '{2'b10, 3'b011, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33},
    '{2'b10, 3'b100, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33},
    '{2'b10, 3'b101, 1'b0, 1'b1, 1'b1, 32'd100,       32'd7,         32'd14,        33},
    '{2'b10, 3'b110, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33},
    '{2'b10, 3'b111, 1'b0, 1'b1, 1'b1, 32'd100,       32'd7,         32'd2,         33},
    '{2'b10, 3'b110, 1'b0, 1'b1, 1'b1, 32'd7,         32'hFFFF_FFFE, 32'd1,         33},
    '{2'b10, 3'b100, 1'b1, 1'b1, 1'b1, 32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 33}
  };

  vec_t sp_vecs [0:5] = '{
    '{2'b10, 3'b101, 1'b0, 1'b1, 1'b1, 32'd7,         32'd0,         32'hFFFF_FFFF, 1},
    '{2'b10, 3'b110, 1'b0, 1'b1, 1'b1, 32'd7,         32'd0,         32'd7,         1},
    '{2'b10, 3'b100, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1},
    '{2'b10, 3'b110, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1},
    '{2'b10, 3'b100, 1'b0, 1'b1, 1'b1, 32'd7,         32'd0,         32'hFFFF_FFFF, 1},
    '{2'b10, 3'b111, 1'b0, 1'b1, 1'b1, 32'd7,         32'd0,         32'd7,         1}
  };

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic f7b5,
                       input logic f7b0, input logic ob5, input logic [31:0] a, input logic [31:0] b);
    alu_op = op; funct3 = f3; funct7b5 = f7b5; funct7b0 = f7b0; opb5 = ob5;
    src_a = a; src_b = b;
  endtask

  // Issues one op from IDLE, waits (bounded) for out_valid, returns what was observed, then consumes it.
  task automatic run_op(input vec_t v, output logic [31:0] res, output logic z, output logic ill,
                        output int lat, output bit rdy_busy, output logic rdy_done);
    drive(v.op, v.f3, v.f7b5, v.f7b0, v.ob5, v.a, v.b);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    rdy_busy = 1'b0;
    while (out_valid !== 1'b1 && lat < 100) begin
      if (in_ready !== 1'b0) rdy_busy = 1'b1;
      tick();
      lat++;
    end
    res = result; z = zero; ill = illegal; rdy_done = in_ready;
    if (out_valid === 1'b1 && out_ready) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    total_cnt++; if (in_ready !== 1'b1)  $display("FAIL reset_in_ready got %b want 1", in_ready); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (result !== 32'd0)   $display("FAIL reset_result got %h want 0", result); else pass_cnt++;
    total_cnt++; if (zero !== 1'b1)      $display("FAIL reset_zero got %b want 1", zero); else pass_cnt++;
    total_cnt++; if (illegal !== 1'b0)   $display("FAIL reset_illegal got %b want 0", illegal); else pass_cnt++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_add();
    vec_t v = '{2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'd5, 32'd7, 32'd12, 1};
    logic [31:0] r; logic z, il, rd; int lat; bit rb;
    run_op(v, r, z, il, lat, rb, rd);
    total_cnt++; if (r !== 32'd12) $display("FAIL add_result got %h want 0000000c", r); else pass_cnt++;
    total_cnt++; if (z !== 1'b0)   $display("FAIL add_zero got %b want 0", z); else pass_cnt++;
    total_cnt++; if (lat != 1)     $display("FAIL add_latency got %0d want 1", lat); else pass_cnt++;
    total_cnt++; if (il !== 1'b0)  $display("FAIL add_illegal got %b want 0", il); else pass_cnt++;
  endtask

  task automatic test_sub_shift();
    vec_t v = '{2'b10, 3'b000, 1'b1, 1'b0, 1'b1, 32'd3, 32'd3, 32'd0, 1};
    logic [31:0] r; logic z, il, rd; int lat; bit rb;
    run_op(v, r, z, il, lat, rb, rd);
    total_cnt++; if (r !== 32'd0 || z !== 1'b1) $display("FAIL sub_zero got result=%h zero=%b want 0/1", r, z); else pass_cnt++;
    v = '{2'b10, 3'b101, 1'b1, 1'b0, 1'b1, 32'h8000_0000, 32'd4, 32'hF800_0000, 1};
    run_op(v, r, z, il, lat, rb, rd);
    total_cnt++; if (r !== 32'hF800_0000) $display("FAIL sra got %h want f8000000", r); else pass_cnt++;
  endtask

  task automatic test_base_ops();
    logic [31:0] r; logic z, il, rd; int lat; bit rb;
    for (int i = 0; i < 14; i++) begin
      run_op(base_vecs[i], r, z, il, lat, rb, rd);
      total_cnt++;
      if (r !== base_vecs[i].exp || lat != 1 || z !== (base_vecs[i].exp == 32'd0))
        $display("FAIL base_vec_%0d got result=%h lat=%0d zero=%b want %h lat=1", i, r, lat, z, base_vecs[i].exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_mulh();
    vec_t v = '{2'b10, 3'b001, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 33};
    logic [31:0] r; logic z, il, rd; int lat; bit rb;
    run_op(v, r, z, il, lat, rb, rd);
    total_cnt++; if (r !== 32'hFFFF_FFFF) $display("FAIL mulh_result got %h want ffffffff", r); else pass_cnt++;
    total_cnt++; if (lat != 33)           $display("FAIL mulh_latency got %0d want 33", lat); else pass_cnt++;
    total_cnt++; if (rb)                  $display("FAIL mulh_in_ready_busy got 1 want 0"); else pass_cnt++;
    total_cnt++; if (rd !== 1'b0)         $display("FAIL mulh_in_ready_done got %b want 0", rd); else pass_cnt++;
  endtask

  task automatic test_m_ops();
    logic [31:0] r; logic z, il, rd; int lat; bit rb;
    for (int i = 0; i < 10; i++) begin
      run_op(m_vecs[i], r, z, il, lat, rb, rd);
      total_cnt++;
      if (r !== m_vecs[i].exp || lat != m_vecs[i].lat || il !== 1'b0)
        $display("FAIL m_vec_%0d got result=%h lat=%0d illegal=%b want %h lat=%0d", i, r, lat, il, m_vecs[i].exp, m_vecs[i].lat);
      else pass_cnt++;
    end
  endtask

  task automatic test_div_specials();
    logic [31:0] r; logic z, il, rd; int lat; bit rb;
    for (int i = 0; i < 6; i++) begin
      run_op(sp_vecs[i], r, z, il, lat, rb, rd);
      total_cnt++;
      if (r !== sp_vecs[i].exp || lat != 1 || z !== (sp_vecs[i].exp == 32'd0))
        $display("FAIL div_special_%0d got result=%h lat=%0d zero=%b want %h lat=1", i, r, lat, z, sp_vecs[i].exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_backpressure();
    bit ok = 1'b1;
    out_ready = 1'b0;
    drive(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'd9, 32'd1);
    in_valid = 1'b1;
    tick();
    drive(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'd1, 32'd1);
    total_cnt++; if (out_valid !== 1'b1 || result !== 32'd10) $display("FAIL bp_first got valid=%b result=%h want 1/0000000a", out_valid, result); else pass_cnt++;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid !== 1'b1 || result !== 32'd10 || in_ready !== 1'b0) ok = 1'b0;
    end
    total_cnt++; if (!ok) $display("FAIL bp_hold got valid=%b result=%h in_ready=%b want 1/0000000a/0", out_valid, result, in_ready); else pass_cnt++;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    total_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL bp_release got valid=%b in_ready=%b want 0/1", out_valid, in_ready); else pass_cnt++;
    tick();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL bp_no_accept_from_done got valid=%b want 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_flush();
    vec_t v = '{2'b10, 3'b101, 1'b0, 1'b1, 1'b1, 32'd100, 32'd7, 32'd14, 33};
    logic [31:0] r; logic z, il, rd; int lat; bit rb; bit seen = 1'b0;
    drive(2'b10, 3'b100, 1'b0, 1'b1, 1'b1, 32'd100, 32'd7);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    total_cnt++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL flush_busy got in_ready=%b valid=%b want 1/0", in_ready, out_valid); else pass_cnt++;
    for (int i = 0; i < 40; i++) begin
      if (out_valid !== 1'b0) seen = 1'b1;
      tick();
    end
    total_cnt++; if (seen) $display("FAIL flush_no_valid got out_valid=1 want 0"); else pass_cnt++;
    drive(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'd1, 32'd2);
    in_valid = 1'b1;
    flush = 1'b1;
    tick();
    in_valid = 1'b0;
    flush = 1'b0;
    total_cnt++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL flush_over_valid got in_ready=%b valid=%b want 1/0", in_ready, out_valid); else pass_cnt++;
    run_op(v, r, z, il, lat, rb, rd);
    total_cnt++; if (r !== 32'd14 || lat != 33) $display("FAIL flush_recover got result=%h lat=%0d want 0000000e lat=33", r, lat); else pass_cnt++;
  endtask

  task automatic test_reset_mid_busy();
    drive(2'b10, 3'b001, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE, 32'd3);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    total_cnt++; if (in_ready !== 1'b1)  $display("FAIL rst_busy_in_ready got %b want 1", in_ready); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_busy_out_valid got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (result !== 32'd0 || zero !== 1'b1 || illegal !== 1'b0)
      $display("FAIL rst_busy_outputs got result=%h zero=%b illegal=%b want 0/1/0", result, zero, illegal);
    else pass_cnt++;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_illegal();
    vec_t v = '{2'b11, 3'b000, 1'b0, 1'b0, 1'b0, 32'd5, 32'd5, 32'd0, 1};
    logic [31:0] r; logic z, il, rd; int lat; bit rb;
    run_op(v, r, z, il, lat, rb, rd);
    total_cnt++; if (il !== 1'b1)              $display("FAIL illegal_flag got %b want 1", il); else pass_cnt++;
    total_cnt++; if (r !== 32'd0 || lat != 1)  $display("FAIL illegal_result got %h lat=%0d want 0 lat=1", r, lat); else pass_cnt++;
    v = '{2'b10, 3'b000, 1'b0, 1'b1, 1'b1, 32'd6, 32'd7, 32'd42, 33};
    run_op(v, r, z, il, lat, rb, rd);
    total_cnt++; if (il !== 1'b0 || r !== 32'd42) $display("FAIL illegal_clear got illegal=%b result=%h want 0/0000002a", il, r); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    vec_t v1 = '{2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'd1, 32'd2, 32'd3, 1};
    vec_t v2 = '{2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 32'h20, 32'h10, 32'h10, 1};
    logic [31:0] r; logic z, il, rd; int lat; bit rb;
    run_op(v1, r, z, il, lat, rb, rd);
    total_cnt++; if (r !== 32'd3)   $display("FAIL b2b_first got %h want 00000003", r); else pass_cnt++;
    run_op(v2, r, z, il, lat, rb, rd);
    total_cnt++; if (r !== 32'h10 || lat != 1) $display("FAIL b2b_second got %h lat=%0d want 00000010 lat=1", r, lat); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_shift();
    test_base_ops();
    test_mulh();
    test_m_ops();
    test_div_specials();
    test_backpressure();
    test_flush();
    test_add();
    test_reset_mid_busy();
    test_illegal();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
